// File: rtl/present_enc_iter_if.sv
// Request/response handshake bundle for the iterative PRESENT encryption core.
// The master side supplies plaintext and key and consumes ciphertext; the core is the slave.
interface present_enc_iter_if #(
  parameter int KEY_WIDTH = 80
);
  logic                 req_valid;
  logic                 req_ready;
  logic [63:0]          req_data;
  logic [KEY_WIDTH-1:0] req_key;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_data;

  modport master (
    output req_valid,
    output req_data,
    output req_key,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_key,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/present_enc_iter.sv
// Iterative PRESENT encryption core that computes one round per clock with an on-the-fly key schedule.
// The key schedule supports 80-bit and 128-bit keys and a reduced round count for testing.
module present_enc_iter #(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  present_enc_iter_if.slave  enc_io
);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
    $error("present_enc_iter: KEY_WIDTH must be 80 or 128");
  end

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_enc_iter: ROUNDS must be in 1..31");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  fsm_e                 fsm_q, fsm_d;
  logic [63:0]          state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [4:0]           rc_q, rc_d;

  logic [63:0]          round_key;
  logic [KEY_WIDTH-1:0] key_rot;
  logic [KEY_WIDTH-1:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y     = '0;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    return y;
  endfunction

  assign round_key = key_q[KEY_WIDTH-1 -: 64];
  assign key_rot   = {key_q[KEY_WIDTH-62:0], key_q[KEY_WIDTH-1:KEY_WIDTH-61]};

  // Key schedule step: rotate left by 61, substitute the top nibble(s), then fold in the round counter.
  if (KEY_WIDTH == 128) begin : g_key128
    always_comb begin
      key_next          = key_rot;
      key_next[127:124] = sbox(key_rot[127:124]);
      key_next[123:120] = sbox(key_rot[123:120]);
      key_next[66:62]   = key_rot[66:62] ^ rc_q;
    end
  end else begin : g_key80
    always_comb begin
      key_next        = key_rot;
      key_next[79:76] = sbox(key_rot[79:76]);
      key_next[19:15] = key_rot[19:15] ^ rc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (enc_io.req_valid) fsm_d = ROUND;
      ROUND:   if (rc_q == LAST_RC)  fsm_d = DONE;
      DONE:    if (enc_io.rsp_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // The datapath only moves on acceptance and during rounds; DONE holds the result steady under backpressure.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    case (fsm_q)
      IDLE: begin
        if (enc_io.req_valid) begin
          state_d = enc_io.req_data;
          key_d   = enc_io.req_key;
          rc_d    = 5'd1;
        end
      end
      ROUND: begin
        state_d = p_layer(s_layer(state_q ^ round_key));
        key_d   = key_next;
        rc_d    = rc_q + 5'd1;
      end
      default: ;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    enc_io.req_ready = 1'b0;
    enc_io.rsp_valid = 1'b0;
    enc_io.rsp_data  = '0;
    case (fsm_q)
      IDLE: enc_io.req_ready = 1'b1;
      DONE: begin
        enc_io.rsp_valid = 1'b1;
        enc_io.rsp_data  = state_q ^ round_key;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_present_enc_iter.sv
// Directed self-checking bench for present_enc_iter: known-answer vectors, latency,
// handshake, backpressure, mid-operation reset and a reduced-round instance.
module tb_present_enc_iter;

  logic clk = 1'b0;
  logic rst_n;
  int   compareCount = 0;
  int   failCount    = 0;

  always #5 clk = ~clk;

  present_enc_iter_if #(.KEY_WIDTH(80))  busA ();
  present_enc_iter_if #(.KEY_WIDTH(128)) busB ();
  present_enc_iter_if #(.KEY_WIDTH(80))  busC ();

  present_enc_iter #(.KEY_WIDTH(80),  .ROUNDS(31)) dutA (.clk(clk), .rst_n(rst_n), .enc_io(busA.slave));
  present_enc_iter #(.KEY_WIDTH(128), .ROUNDS(31)) dutB (.clk(clk), .rst_n(rst_n), .enc_io(busB.slave));
  present_enc_iter #(.KEY_WIDTH(80),  .ROUNDS(1))  dutC (.clk(clk), .rst_n(rst_n), .enc_io(busC.slave));

  // Reference model, written per output bit rather than per input bit.
  function automatic logic [3:0] sboxM(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] sLayerM(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sboxM(x[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] pLayerM(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 16; k++) r[16*b + k] = x[4*k + b];
    return r;
  endfunction

  function automatic logic [79:0] keyUpd80M(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r        = {k[18:0], k[79:19]};
    r[79:76] = sboxM(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic getReady(input int sel);
    case (sel)
      0:       return busA.req_ready;
      1:       return busB.req_ready;
      default: return busC.req_ready;
    endcase
  endfunction

  function automatic logic getValid(input int sel);
    case (sel)
      0:       return busA.rsp_valid;
      1:       return busB.rsp_valid;
      default: return busC.rsp_valid;
    endcase
  endfunction

  function automatic logic [63:0] getData(input int sel);
    case (sel)
      0:       return busA.rsp_data;
      1:       return busB.rsp_data;
      default: return busC.rsp_data;
    endcase
  endfunction

  task automatic driveReq(input int sel, input logic valid, input logic [63:0] pt, input logic [127:0] key);
    case (sel)
      0: begin busA.req_valid = valid; busA.req_data = pt; busA.req_key = key[79:0]; end
      1: begin busB.req_valid = valid; busB.req_data = pt; busB.req_key = key;       end
      default: begin busC.req_valid = valid; busC.req_data = pt; busC.req_key = key[79:0]; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for req_ready, then presents the request for exactly the accept edge.
  task automatic applyStimulus(input int sel, input logic [63:0] pt, input logic [127:0] key);
    int waitCnt;
    waitCnt = 0;
    while (!getReady(sel) && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("accept_ready", 64'(getReady(sel)), 64'd1);
    driveReq(sel, 1'b1, pt, key);
    @(posedge clk); #1;
    driveReq(sel, 1'b0, 64'h0, 128'h0);
  endtask

  // Counts edges after the accept edge until rsp_valid; optionally disturbs the request inputs meanwhile.
  task automatic waitRsp(input int sel, input bit scramble, output int lat);
    int readyHigh;
    lat       = 0;
    readyHigh = 0;
    do begin
      if (scramble && lat == 10) driveReq(sel, 1'b1, 64'hDEADBEEFCAFEF00D, 128'h0123456789ABCDEF0011223344556677);
      if (scramble && lat == 20) driveReq(sel, 1'b0, 64'h0, 128'h0);
      @(posedge clk); #1;
      lat++;
      if (getReady(sel)) readyHigh++;
    end while (!getValid(sel) && lat < 200);
    checkOutput("req_ready_low_during_op", 64'(readyHigh), 64'd0);
  endtask

  // Completes the response handshake (rsp_ready must already be high) and checks the return to IDLE.
  task automatic finishHandshake(input int sel, input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_post_rsp_valid"}, 64'(getValid(sel)), 64'd0);
    checkOutput({tag, "_post_rsp_data"},  getData(sel),        64'h0);
    checkOutput({tag, "_post_req_ready"}, 64'(getReady(sel)),  64'd1);
  endtask

  task automatic encryptA(input string tag, input logic [63:0] pt, input logic [79:0] key,
                          input logic [63:0] expected, input bit scramble);
    int lat;
    applyStimulus(0, pt, {48'h0, key});
    waitRsp(0, scramble, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd31);
    checkOutput({tag, "_ct"}, busA.rsp_data, expected);
    finishHandshake(0, tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          violations;
    logic [63:0] heldData;
    logic [79:0] k1;
    logic [79:0] k2;
    logic [63:0] expC;

    $display("[TB] start");
    driveReq(0, 1'b0, 64'h0, 128'h0);
    driveReq(1, 1'b0, 64'h0, 128'h0);
    driveReq(2, 1'b0, 64'h0, 128'h0);
    busA.rsp_ready = 1'b1;
    busB.rsp_ready = 1'b1;
    busC.rsp_ready = 1'b1;

    // Reset asserted before any clock edge: outputs must already show reset values.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_req_ready", 64'(busA.req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(busA.rsp_valid), 64'd0);
    checkOutput("reset_rsp_data",  busA.rsp_data,       64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] 80-bit known-answer vectors");
    encryptA("kat0", 64'h0,                {80{1'b0}}, 64'h5579C1387B228445, 1'b0);
    encryptA("kat1", 64'hFFFFFFFFFFFFFFFF, {80{1'b0}}, 64'hA112FFC72F68417B, 1'b0);
    encryptA("kat2", 64'h0,                {80{1'b1}}, 64'hE72C46C0F5945049, 1'b1);
    encryptA("kat3", 64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);

    $display("[TB] backpressure");
    busA.rsp_ready = 1'b0;
    applyStimulus(0, 64'h0, 128'h0);
    waitRsp(0, 1'b0, lat);
    checkOutput("bp_latency", 64'(lat), 64'd31);
    heldData   = busA.rsp_data;
    violations = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!busA.rsp_valid || busA.rsp_data !== heldData) violations++;
    end
    checkOutput("bp_hold_violations", 64'(violations), 64'd0);
    checkOutput("bp_ct", busA.rsp_data, 64'h5579C1387B228445);
    busA.rsp_ready = 1'b1;
    finishHandshake(0, "bp");

    $display("[TB] reset mid-operation");
    applyStimulus(0, 64'h0123456789ABCDEF, {48'h0, {80{1'b1}}});
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_req_ready", 64'(busA.req_ready), 64'd1);
    checkOutput("midrst_rsp_valid", 64'(busA.rsp_valid), 64'd0);
    checkOutput("midrst_rsp_data",  busA.rsp_data,       64'h0);
    violations = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busA.rsp_valid) violations++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (busA.rsp_valid || !busA.req_ready) violations++;
    end
    checkOutput("midrst_no_response", 64'(violations), 64'd0);
    encryptA("postrst", 64'h0, {80{1'b0}}, 64'h5579C1387B228445, 1'b0);

    $display("[TB] 128-bit key");
    applyStimulus(1, 64'h0, 128'h0);
    waitRsp(1, 1'b0, lat);
    checkOutput("k128_latency", 64'(lat), 64'd31);
    checkOutput("k128_ct", busB.rsp_data, 64'h96DB702A2E6900AF);
    finishHandshake(1, "k128");

    $display("[TB] reduced rounds");
    k1   = '0;
    k2   = keyUpd80M(k1, 5'd1);
    expC = pLayerM(sLayerM(64'h0 ^ k1[79:16])) ^ k2[79:16];
    applyStimulus(2, 64'h0, 128'h0);
    waitRsp(2, 1'b0, lat);
    checkOutput("r1_latency", 64'(lat), 64'd1);
    checkOutput("r1_ct", busC.rsp_data, expC);
    finishHandshake(2, "r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
